// File: rtl/depar_seg_merge.sv
// depar_seg_merge
//   Deparser output stage. Reassembles each packet from three first-word
//   fall-through FIFOs, in this order: the rewritten first segment, the
//   rewritten second segment, then the untouched remaining segments. The
//   result is emitted as one registered AXI-Stream.
//
// Ports
//   clk, aresetn                 clock; asynchronous active-low reset
//   fst_seg_* / fst_seg_empty    first-segment FIFO head; fst_seg_rd_en pops it
//   snd_seg_* / snd_seg_empty    second-segment FIFO head; snd_seg_rd_en pops it
//   rem_seg_* / rem_seg_empty    remaining-segment FIFO head; rem_seg_rd_en pops it
//   m_axis_*                     registered output beat with valid/ready
//   pkt_cnt                      packets fully emitted (tlast handshakes), wraps
module depar_seg_merge #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            aresetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    fst_seg_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   fst_seg_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  fst_seg_tkeep,
  input  logic                            fst_seg_tlast,
  input  logic                            fst_seg_empty,
  output logic                            fst_seg_rd_en,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    snd_seg_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   snd_seg_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  snd_seg_tkeep,
  input  logic                            snd_seg_tlast,
  input  logic                            snd_seg_empty,
  output logic                            snd_seg_rd_en,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    rem_seg_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   rem_seg_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  rem_seg_tkeep,
  input  logic                            rem_seg_tlast,
  input  logic                            rem_seg_empty,
  output logic                            rem_seg_rd_en,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,

  output logic [31:0]                     pkt_cnt
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  localparam logic [1:0] SEND_FST = 2'd0;
  localparam logic [1:0] SEND_SND = 2'd1;
  localparam logic [1:0] SEND_REM = 2'd2;

  logic [1:0]                    state;
  logic [1:0]                    nxt_state;
  logic                          avail;
  logic                          load;
  logic                          pop;
  logic [C_AXIS_DATA_WIDTH-1:0]  src_tdata;
  logic [C_AXIS_TUSER_WIDTH-1:0] src_tuser;
  logic [KW-1:0]                 src_tkeep;
  logic                          src_tlast;

  // Source selection: the current state owns exactly one FIFO. A first
  // segment with tlast=1 is a single-segment packet whose duplicate copy
  // sits in the second-segment FIFO; both copies must be present so they
  // can be retired together.
  always_comb begin
    avail     = 1'b0;
    nxt_state = state;
    src_tdata = fst_seg_tdata;
    src_tuser = fst_seg_tuser;
    src_tkeep = fst_seg_tkeep;
    src_tlast = fst_seg_tlast;
    case (state)
      SEND_FST: begin
        avail     = !fst_seg_empty && (!fst_seg_tlast || !snd_seg_empty);
        nxt_state = fst_seg_tlast ? SEND_FST : SEND_SND;
      end
      SEND_SND: begin
        avail     = !snd_seg_empty;
        src_tdata = snd_seg_tdata;
        src_tuser = snd_seg_tuser;
        src_tkeep = snd_seg_tkeep;
        src_tlast = snd_seg_tlast;
        nxt_state = snd_seg_tlast ? SEND_FST : SEND_REM;
      end
      SEND_REM: begin
        avail     = !rem_seg_empty;
        src_tdata = rem_seg_tdata;
        src_tuser = rem_seg_tuser;
        src_tkeep = rem_seg_tkeep;
        src_tlast = rem_seg_tlast;
        nxt_state = rem_seg_tlast ? SEND_FST : SEND_REM;
      end
      default: begin
        avail     = 1'b0;
        nxt_state = SEND_FST;
      end
    endcase
  end

  // The output register accepts a new beat when empty or being drained.
  // Reset gates the pops so no FIFO entry is consumed while held in reset.
  assign load = !m_axis_tvalid || m_axis_tready;
  assign pop  = aresetn && load && avail;

  assign fst_seg_rd_en = pop && (state == SEND_FST);
  assign snd_seg_rd_en = pop && ((state == SEND_SND) ||
                                 ((state == SEND_FST) && fst_seg_tlast));
  assign rem_seg_rd_en = pop && (state == SEND_REM);

  // Stage boundary: FIFO heads -> registered AXI-Stream output
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= SEND_FST;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_cnt       <= 32'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        pkt_cnt <= pkt_cnt + 32'd1;
      if (load) begin
        if (avail) begin
          m_axis_tdata  <= src_tdata;
          m_axis_tuser  <= src_tuser;
          m_axis_tkeep  <= src_tkeep;
          m_axis_tlast  <= src_tlast;
          m_axis_tvalid <= 1'b1;
          state         <= nxt_state;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_depar_seg_merge.sv
// tb_depar_seg_merge
//   Testbench for depar_seg_merge. The three upstream FIFOs are modelled as
//   queues. Packets are split into first/second/remaining segments the way
//   the upstream stage does it, and every beat of the reassembled packet is
//   pushed to an expected queue that a separate monitor drains on each
//   output handshake.
module tb_depar_seg_merge;

  localparam int DW = 512;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] fst_seg_tdata, snd_seg_tdata, rem_seg_tdata;
  logic [UW-1:0] fst_seg_tuser, snd_seg_tuser, rem_seg_tuser;
  logic [KW-1:0] fst_seg_tkeep, snd_seg_tkeep, rem_seg_tkeep;
  logic          fst_seg_tlast, snd_seg_tlast, rem_seg_tlast;
  logic          fst_seg_empty, snd_seg_empty, rem_seg_empty;
  logic          fst_seg_rd_en, snd_seg_rd_en, rem_seg_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [31:0]   pkt_cnt;

  depar_seg_merge #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) dut (
    .clk(clk), .aresetn(aresetn),
    .fst_seg_tdata(fst_seg_tdata), .fst_seg_tuser(fst_seg_tuser),
    .fst_seg_tkeep(fst_seg_tkeep), .fst_seg_tlast(fst_seg_tlast),
    .fst_seg_empty(fst_seg_empty), .fst_seg_rd_en(fst_seg_rd_en),
    .snd_seg_tdata(snd_seg_tdata), .snd_seg_tuser(snd_seg_tuser),
    .snd_seg_tkeep(snd_seg_tkeep), .snd_seg_tlast(snd_seg_tlast),
    .snd_seg_empty(snd_seg_empty), .snd_seg_rd_en(snd_seg_rd_en),
    .rem_seg_tdata(rem_seg_tdata), .rem_seg_tuser(rem_seg_tuser),
    .rem_seg_tkeep(rem_seg_tkeep), .rem_seg_tlast(rem_seg_tlast),
    .rem_seg_empty(rem_seg_empty), .rem_seg_rd_en(rem_seg_rd_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  beat_t fst_q[$], snd_q[$], rem_q[$], exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    pkts_issued = 0;
  logic  last_rf, last_rs, last_rr;

  task automatic chk(input string nm, input logic [1023:0] a, input logic [1023:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom();
    for (int i = 0; i < UW / 32; i++) b.u[i*32 +: 32] = $urandom();
    b.k = {$urandom(), $urandom()};
    b.l = last;
    return b;
  endfunction

  function automatic beat_t out_beat();
    beat_t b;
    b.d = m_axis_tdata;
    b.u = m_axis_tuser;
    b.k = m_axis_tkeep;
    b.l = m_axis_tlast;
    return b;
  endfunction

  // Split an n-beat packet into the three upstream FIFOs; a single-beat
  // packet appears in both the first- and second-segment FIFOs.
  task automatic push_pkt(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = rand_beat(i == n - 1);
      if (i == 0) begin
        fst_q.push_back(b);
        if (n == 1) snd_q.push_back(b);
      end else if (i == 1) begin
        snd_q.push_back(b);
      end else begin
        rem_q.push_back(b);
      end
      exp_q.push_back(b);
    end
    pkts_issued++;
  endtask

  task automatic set_heads();
    beat_t z;
    z = '0;
    fst_seg_empty = (fst_q.size() == 0);
    snd_seg_empty = (snd_q.size() == 0);
    rem_seg_empty = (rem_q.size() == 0);
    {fst_seg_tdata, fst_seg_tuser, fst_seg_tkeep, fst_seg_tlast} = fst_seg_empty ? z : fst_q[0];
    {snd_seg_tdata, snd_seg_tuser, snd_seg_tkeep, snd_seg_tlast} = snd_seg_empty ? z : snd_q[0];
    {rem_seg_tdata, rem_seg_tuser, rem_seg_tkeep, rem_seg_tlast} = rem_seg_empty ? z : rem_q[0];
  endtask

  // One clock: sample pops and protocol rules on the falling edge, let the
  // FIFO model retire popped entries at the rising edge, then refresh heads.
  task automatic step();
    @(negedge clk);
    last_rf = fst_seg_rd_en;
    last_rs = snd_seg_rd_en;
    last_rr = rem_seg_rd_en;
    if (aresetn) begin
      if (last_rf) chk("fst_pop_nonempty", fst_seg_empty, 0);
      if (last_rs) chk("snd_pop_nonempty", snd_seg_empty, 0);
      if (last_rr) chk("rem_pop_nonempty", rem_seg_empty, 0);
      if (last_rf) chk("fst_snd_pair_pop", last_rs, fst_seg_tlast);
      if (last_rr) chk("rem_pop_alone", last_rf | last_rs, 0);
      if (m_axis_tvalid && !m_axis_tready) chk("bp_no_pop", last_rf | last_rs | last_rr, 0);
    end
    @(posedge clk);
    if (last_rf && fst_q.size() > 0) void'(fst_q.pop_front());
    if (last_rs && snd_q.size() > 0) void'(snd_q.pop_front());
    if (last_rr && rem_q.size() > 0) void'(rem_q.pop_front());
    #1;
    set_heads();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk({nm, "_drain_timeout"}, exp_q.size(), 0);
    step();
    chk({nm, "_pkt_cnt"}, pkt_cnt, pkts_issued);
    chk({nm, "_idle_tvalid"}, m_axis_tvalid, 0);
  endtask

  // Scoreboard monitor: pops one expected beat per output handshake and
  // checks that a stalled beat is held unchanged.
  beat_t held;
  logic  stalled = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (!aresetn) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_tvalid_hold", m_axis_tvalid, 1);
        chk("stall_beat_hold", out_beat(), held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", out_beat(), e);
        end
      end
      stalled <= m_axis_tvalid && !m_axis_tready;
      held    <= out_beat();
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t a;
    int    cyc;

    // Reset: a non-empty head must not be popped while reset is held.
    fst_q.push_back(rand_beat(1'b0));
    set_heads();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_rd_en", {fst_seg_rd_en, snd_seg_rd_en, rem_seg_rd_en}, 0);
    fst_q.delete();
    set_heads();
    aresetn = 1'b1;
    m_axis_tready = 1'b1;

    // Single-beat packet: fst and snd pop together, one beat with tlast.
    push_pkt(1);
    set_heads();
    a = fst_q[0];
    step();
    chk("1beat_pair_pop", {last_rf, last_rs, last_rr}, 3'b110);
    chk("1beat_latency_tvalid", m_axis_tvalid, 1);
    chk("1beat_data", out_beat(), a);
    drain("1beat");

    // Four-beat packet in four consecutive cycles.
    push_pkt(4);
    set_heads();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("4beat_tvalid", m_axis_tvalid, 1);
      chk("4beat_tlast", m_axis_tlast, (i == 3));
    end
    drain("4beat");

    // Two back-to-back three-beat packets: no bubble at the boundary.
    push_pkt(3);
    push_pkt(3);
    set_heads();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b2b_no_bubble", m_axis_tvalid, 1);
    end
    drain("b2b");

    // Single-segment head waiting on its second-segment copy.
    a = rand_beat(1'b1);
    fst_q.push_back(a);
    exp_q.push_back(a);
    pkts_issued++;
    set_heads();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_snd_tvalid", m_axis_tvalid, 0);
      chk("wait_snd_no_pop", {last_rf, last_rs, last_rr}, 0);
    end
    snd_q.push_back(a);
    set_heads();
    step();
    chk("wait_snd_emit_tvalid", m_axis_tvalid, 1);
    chk("wait_snd_emit_data", out_beat(), a);
    drain("wait_snd");

    // Randomized traffic with 50% ready.
    cyc = 0;
    begin
      int sent;
      sent = 0;
      while ((sent < 200 || exp_q.size() != 0) && cyc < 20000) begin
        if (sent < 200 && fst_q.size() < 4 && $urandom_range(0, 1) == 1) begin
          push_pkt($urandom_range(1, 10));
          sent++;
        end
        set_heads();
        m_axis_tready = ($urandom_range(0, 1) == 1);
        step();
        cyc++;
      end
      chk("rand_all_sent", sent, 200);
    end
    m_axis_tready = 1'b1;
    drain("rand");

    // Reset in the middle of a five-beat packet.
    push_pkt(5);
    set_heads();
    step();
    step();
    aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    chk("midrst_rd_en", {fst_seg_rd_en, snd_seg_rd_en, rem_seg_rd_en}, 0);
    fst_q.delete();
    snd_q.delete();
    rem_q.delete();
    exp_q.delete();
    pkts_issued = 0;
    set_heads();
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    push_pkt(2);
    set_heads();
    a = fst_q[0];
    step();
    chk("postrst_first_beat", out_beat(), a);
    drain("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
